// File: rtl/aurora_frame_pkg.sv
// Shared Aurora framing definitions used by the sender and the receiver:
// beat width, sync word, header field positions and the frame state encoding.
package aurora_frame_pkg;

  localparam int unsigned BEAT_W   = 256;

  localparam logic [63:0] SYNC_WORD = 64'h0000_0000_1acf_fc1d;

  // Header field positions within a beat
  localparam int unsigned CNT_LSB  = 240;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SIZE_LSB = 208;
  localparam int unsigned SIZE_W   = 16;
  localparam int unsigned SYNC_LSB = 128;
  localparam int unsigned SYNC_W   = 64;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Header beat: frame count, payload size and sync word; every other bit is 0
  function automatic beat_t make_header(input logic [CNT_W-1:0]  cnt,
                                        input logic [SIZE_W-1:0] size);
    beat_t hdr;
    hdr = '0;
    hdr[CNT_LSB  +: CNT_W]  = cnt;
    hdr[SIZE_LSB +: SIZE_W] = size;
    hdr[SYNC_LSB +: SYNC_W] = SYNC_WORD;
    return hdr;
  endfunction

endpackage

// File: rtl/data_send_if.sv
// Handshake bundle for data_send.
//   enable              : frame generation enable (level)
//   src_valid/src_data  : payload source word, src_ready consumes it
//   m_tvalid/m_tready   : AXI-stream handshake toward the Aurora TX user port
//   m_tdata/m_tlast     : AXI-stream beat and end-of-frame marker
// master: the sender side (data_send); slave: the environment around it.
interface data_send_if;
  import aurora_frame_pkg::*;

  logic  enable;
  logic  src_valid;
  beat_t src_data;
  logic  src_ready;
  logic  m_tvalid;
  logic  m_tready;
  beat_t m_tdata;
  logic  m_tlast;

  modport master (
    input  enable, src_valid, src_data, m_tready,
    output src_ready, m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    output enable, src_valid, src_data, m_tready,
    input  src_ready, m_tvalid, m_tdata, m_tlast
  );

endinterface

// File: rtl/axis_out_reg.sv
// One-entry AXI-stream output register.
//   clk, rst                         : clock, async active-high reset
//   load_valid/load_data/load_last   : beat offered by the frame FSM
//   can_load_c                       : register accepts a beat this cycle
//   m_tready                         : downstream ready
//   m_tvalid/m_tdata/m_tlast         : registered stream outputs
module axis_out_reg
  import aurora_frame_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_valid,
  input  beat_t load_data,
  input  logic  load_last,
  output logic  can_load_c,
  input  logic  m_tready,
  output logic  m_tvalid,
  output beat_t m_tdata,
  output logic  m_tlast
);

  logic  valid_q, valid_d;
  beat_t data_q,  data_d;
  logic  last_q,  last_d;

  // Empty, or the current beat leaves this cycle: load and accept overlap
  assign can_load_c = !valid_q || m_tready;

  // Next contents; everything holds while stalled
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (can_load_c) begin
      valid_d = load_valid;
      last_d  = 1'b0;
      if (load_valid) begin
        data_d = load_data;
        last_d = load_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign m_tvalid = valid_q;
  assign m_tdata  = data_q;
  assign m_tlast  = last_q;

endmodule

// File: rtl/data_send.sv
// Aurora frame sender: header beat + FRAME_SIZE/32 payload beats, then a gap.
//   clk, rst   : clock, async active-high reset
//   bus        : data_send_if.master (enable, payload source, AXI-stream out)
//   busy       : high whenever the FSM is not idle
//   frame_cnt  : completed frames modulo 256
// Build option DATA_SEND_PATTERN_EN: payload is an internal 32-bit
// incrementing counter replicated across the beat; the source is ignored.
module data_send
  import aurora_frame_pkg::*;
#(
  parameter logic [15:0] FRAME_SIZE = 16'd1024,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  data_send_if.master       bus,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned N_BEATS  = 32'(FRAME_SIZE) / 32;
  localparam int unsigned BEAT_CW  = 16;
  localparam int unsigned GAP_W    = 32;
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  state_e             state_q, state_d;
  logic [BEAT_CW-1:0] beat_q, beat_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               busy_q, busy_d;

  logic  load_valid, load_last, can_load_c;
  beat_t load_data;
  beat_t payload_c;
  logic  pay_avail_c, load_room_c, pay_take_c, remaining_c, last_acc_c;

  assign remaining_c = beat_q < BEAT_CW'(N_BEATS);
  assign load_room_c = (state_q == ST_DATA) && remaining_c && can_load_c;
  assign pay_take_c  = load_room_c && pay_avail_c;
  assign last_acc_c  = bus.m_tvalid && bus.m_tready && bus.m_tlast;

`ifdef DATA_SEND_PATTERN_EN
  logic [31:0] pat_q, pat_d;

  assign pay_avail_c   = 1'b1;
  assign payload_c     = {8{pat_q}};
  assign bus.src_ready = 1'b0;

  // Pattern word advances once per loaded payload beat, across frames
  always_comb begin
    pat_d = pat_q;
    if (pay_take_c) pat_d = pat_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pat_q <= '0;
    else     pat_q <= pat_d;
  end
`else
  assign pay_avail_c   = bus.src_valid;
  assign payload_c     = bus.src_data;
  assign bus.src_ready = load_room_c;
`endif

  // Frame sequencing and counters
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    frame_cnt_d = frame_cnt_q;
    busy_d      = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable) state_d = ST_HEAD;
      end
      ST_HEAD: begin
        beat_d = '0;
        if (can_load_c) begin
          load_valid = 1'b1;
          load_data  = make_header(frame_cnt_q, FRAME_SIZE);
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pay_take_c) begin
          load_valid = 1'b1;
          load_data  = payload_c;
          load_last  = (beat_q == BEAT_CW'(N_BEATS - 1));
          beat_d     = beat_q + BEAT_CW'(1);
        end
        // Frame ends only when the tlast beat actually leaves
        if (last_acc_c) begin
          state_d     = ST_GAP;
          gap_d       = '0;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) state_d = ST_IDLE;
        else                           gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      gap_q       <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
    end
  end

  axis_out_reg u_out (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .can_load_c (can_load_c),
    .m_tready   (bus.m_tready),
    .m_tvalid   (bus.m_tvalid),
    .m_tdata    (bus.m_tdata),
    .m_tlast    (bus.m_tlast)
  );

  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/data_send.md
DATA_SEND -- requirements
Module: data_send

Interface
REQ-001 SHALL have parameter FRAME_SIZE, default 16'd1024, payload bytes per frame; multiple of 32, range 64..65504.
REQ-002 SHALL have parameter GAP_CYCLES, default 4, idle cycles between frames; 0 permitted.
REQ-003 SHALL have clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have enable  input  1  level; frames are sent while high.
REQ-006 SHALL have src_valid  input  1  payload word available.
REQ-007 SHALL have src_data  input  256  payload word.
REQ-008 SHALL have src_ready  output  1  payload word consumed this cycle when src_valid is also high.
REQ-009 SHALL have m_tvalid  output  1  AXI-stream valid toward the Aurora TX user port.
REQ-010 SHALL have m_tready  input  1  AXI-stream ready from the Aurora core.
REQ-011 SHALL have m_tdata  output  256  AXI-stream data.
REQ-012 SHALL have m_tlast  output  1  final beat of frame.
REQ-013 SHALL have busy  output  1  high in every state except IDLE.
REQ-014 SHALL have frame_cnt  output  8  count of completed frames, modulo 256.

Function
REQ-015 SHALL emit each frame as 1 header beat followed by FRAME_SIZE/32 payload beats.
REQ-016 Header beat SHALL carry [247:240]=frame_cnt, [223:208]=FRAME_SIZE, [191:128]=64'h0000_0000_1acf_fc1d, all other bits 0.
REQ-017 Payload beats SHALL carry src_data unchanged, in arrival order.
REQ-018 m_tlast SHALL be high only on the last payload beat.
REQ-019 Header beats SHALL have m_tlast low; 0 on all other beats.
REQ-020 m_tdata and m_tlast SHALL be driven from a one-entry output register.
REQ-021 The output register SHALL load when empty or when m_tvalid&&m_tready.
REQ-022 While m_tvalid=1 && m_tready=0, m_tdata, m_tlast and m_tvalid SHALL hold stable.
REQ-023 src_ready SHALL be high only in DATA state, only while payload beats remain to load, and only when the output register can load that cycle.
REQ-024 Payload latency SHALL be 1 cycle: a word accepted on cycle N appears on m_tdata on cycle N+1.
REQ-025 States: IDLE -> HEAD when enable=1.
REQ-026 HEAD loads the header beat -> DATA.
REQ-027 DATA -> GAP once the tlast beat is accepted (m_tvalid&&m_tready&&m_tlast).
REQ-028 GAP counts GAP_CYCLES -> IDLE; with GAP_CYCLES=0, GAP lasts 1 cycle.
REQ-029 A beat counter SHALL reset at HEAD and increment per loaded payload beat.
REQ-030 The last beat SHALL be the one loaded when count == FRAME_SIZE/32-1.
REQ-031 src_valid=0 in DATA SHALL insert bubbles (m_tvalid=0 after drain), never drop or duplicate words.
REQ-032 frame_cnt SHALL increment by 1 when the tlast beat is accepted; 255 wraps to 0.
REQ-033 enable falling mid-frame SHALL NOT abort the frame; it takes effect only in IDLE.
REQ-034 A simultaneous output-register load and downstream accept SHALL sustain 1 beat/cycle.

Reset
REQ-035 rst SHALL force state=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, src_ready=0, busy=0, frame_cnt=0, beat and gap counters 0.
REQ-036 rst asserted mid-frame SHALL drop m_tvalid immediately; the partial frame is abandoned.
REQ-037 After rst deasserts, the first frame SHALL carry frame_cnt=0.

Configuration
REQ-038 With macro DATA_SEND_PATTERN_EN defined, payload beats SHALL be an internal 32-bit incrementing counter replicated 8x across 256 bits.
REQ-039 With DATA_SEND_PATTERN_EN, the counter SHALL start at 0 after reset and increment per payload beat; src_valid is ignored and src_ready is held 0.
REQ-040 Without DATA_SEND_PATTERN_EN, payload SHALL come from src_data and no pattern logic is present.

Structure
REQ-041 Package aurora_frame_pkg SHALL hold SYNC_WORD, header field bit positions (CNT, SIZE, SYNC), beat width 256, and the state enumeration; it is shared with the receiver.
REQ-042 The output register/handshake SHALL be sub-module axis_out_reg; the state machine, counters and pattern generator stay in data_send.

Verification
REQ-043 FRAME_SIZE=64, m_tready=1, src_valid=1, enable=1 -> beats: header, 2 payload, tlast on beat 3; header [191:128]=1acffc1d, [223:208]=0x0040, [247:240]=0x00.
REQ-044 m_tready toggled 0/1 each cycle during a frame -> m_tdata is stable through every stall; all 33 beats of a FRAME_SIZE=1024 frame arrive in order.
REQ-045 src_valid low for 5 cycles mid-payload -> m_tvalid gaps; no word lost or repeated; tlast still on the 32nd payload beat.
REQ-046 Run 257 frames -> frame_cnt reads 0..255, then 0 in the 257th header.
REQ-047 rst pulsed on payload beat 10 -> m_tvalid=0 the same cycle; next frame header cnt=0.
REQ-048 DATA_SEND_PATTERN_EN defined, FRAME_SIZE=96 -> payload words 0,1,2 replicated per 32-bit lane; src_ready stays 0.
